// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with legacy or show-ahead read port, programmable
// almost-full/almost-empty thresholds, synchronous clear and overflow/underflow pulses.
module fifo_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 8,
  parameter bit SHOW_AHEAD = 1'b0,
  parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  wr_ovf,
  output logic                  rd_unf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_CNT   = (DEPTH_LOG2 + 1)'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0] AE_CNT   = (DEPTH_LOG2 + 1)'(AE_LEVEL);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   usedw_q, usedw_d;
  logic                  full_q, empty_q, almost_full_q, almost_empty_q;
  logic                  wr_ovf_q, rd_unf_q;
  logic                  wr_acc, rd_acc;

  // Handshake: wrreq/rdreq are accepted only when this cycle's full/empty flag allows;
  // a read never frees room for a same-cycle write, a write never feeds a same-cycle read.
  // Rejected requests leave all state untouched and raise the matching error pulse.
  assign wr_acc = wrreq && !full_q;
  assign rd_acc = rdreq && !empty_q;

  always_comb begin
    usedw_d = usedw_q;
    if (wr_acc && !rd_acc) begin
      usedw_d = usedw_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      usedw_d = usedw_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      usedw_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      wr_ovf_q       <= 1'b0;
      rd_unf_q       <= 1'b0;
    end else if (sclr) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      usedw_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      wr_ovf_q       <= 1'b0;
      rd_unf_q       <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      usedw_q        <= usedw_d;
      full_q         <= (usedw_d == FULL_CNT);
      empty_q        <= (usedw_d == '0);
      almost_full_q  <= (usedw_d >= AF_CNT);
      almost_empty_q <= (usedw_d < AE_CNT);
      wr_ovf_q       <= wrreq && full_q;
      rd_unf_q       <= rdreq && empty_q;
    end
  end

  // Storage is deliberately not reset or cleared; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_acc && !sclr) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      assign q = mem_q[rd_ptr_q];
    end else begin : g_legacy
      logic [WIDTH-1:0] q_q;
      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          q_q <= '0;
        end else if (sclr) begin
          q_q <= '0;
        end else if (rd_acc) begin
          q_q <= mem_q[rd_ptr_q];
        end
      end
      assign q = q_q;
    end
  endgenerate

  assign usedw        = usedw_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign wr_ovf       = wr_ovf_q;
  assign rd_unf       = rd_unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: one legacy and one show-ahead instance (8 x 8 words)
// share the same stimulus; read data is scored against an expected queue.
module tb_fifo_param;

  logic       clock;
  logic       aclr_n;
  logic       sclr;
  logic [7:0] data;
  logic       wrreq;
  logic       rdreq;

  logic [7:0] l_q, s_q;
  logic       l_full, l_empty, l_af, l_ae, l_ovf, l_unf;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [3:0] l_usedw, s_usedw;

  int n_vec = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_q;
  logic [7:0] exp_word;

  fifo_param #(.WIDTH(8), .DEPTH_LOG2(3), .SHOW_AHEAD(1'b0), .AF_LEVEL(4), .AE_LEVEL(4)) u_leg (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(l_q), .full(l_full), .empty(l_empty), .almost_full(l_af), .almost_empty(l_ae),
    .usedw(l_usedw), .wr_ovf(l_ovf), .rd_unf(l_unf)
  );

  fifo_param #(.WIDTH(8), .DEPTH_LOG2(3), .SHOW_AHEAD(1'b1), .AF_LEVEL(4), .AE_LEVEL(4)) u_sa (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(s_q), .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .usedw(s_usedw), .wr_ovf(s_ovf), .rd_unf(s_unf)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // one clock: inputs were set beforehand, outputs are sampled 1ns after the edge
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    wrreq = w;
    rdreq = r;
    data  = d;
  endtask

  initial begin
    aclr_n = 1'b1;
    sclr   = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    #1 aclr_n = 1'b0;
    #1;
    check("rst_usedw", l_usedw, 4'd0);
    check("rst_empty", l_empty, 1'b1);
    check("rst_full", l_full, 1'b0);
    check("rst_ae", l_ae, 1'b1);
    check("rst_af", l_af, 1'b0);
    check("rst_ovf", l_ovf, 1'b0);
    check("rst_unf", l_unf, 1'b0);
    check("rst_q", l_q, 8'h00);
    check("rst_sa_empty", s_empty, 1'b1);
    #6 aclr_n = 1'b1;

    // fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      exp_q.push_back(8'(i));
      cycle();
      check("fill_usedw", l_usedw, 32'(i));
      check("fill_af", l_af, (i >= 4) ? 1 : 0);
      check("fill_full", l_full, (i == 8) ? 1 : 0);
      check("fill_empty", l_empty, 1'b0);
      check("fill_sa_head", s_q, 8'h01);
    end

    // drain in legacy mode, q follows each rdreq edge
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      cycle();
      exp_word = exp_q.pop_front();
      check("drain_q", l_q, exp_word);
      check("drain_usedw", l_usedw, 32'(8 - i));
      check("drain_ae", l_ae, ((8 - i) < 4) ? 1 : 0);
      check("drain_empty", l_empty, (i == 8) ? 1 : 0);
      if (i < 8) check("drain_sa_head", s_q, 32'(i + 1));
    end
    last_q = 8'h08;

    // empty with both requests: write only, underflow pulse
    drive(1'b1, 1'b1, 8'h33);
    exp_q.push_back(8'h33);
    cycle();
    check("unf_usedw", l_usedw, 4'd1);
    check("unf_pulse", l_unf, 1'b1);
    check("unf_no_ovf", l_ovf, 1'b0);
    check("unf_q_hold", l_q, last_q);
    drive(1'b0, 1'b0, 8'h00);
    cycle();
    check("unf_pulse_end", l_unf, 1'b0);

    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + k));
      exp_q.push_back(8'(8'h40 + k));
      cycle();
    end
    check("refill_full", l_full, 1'b1);
    check("refill_usedw", l_usedw, 4'd8);

    // full with both requests: read only, word dropped, overflow pulse
    drive(1'b1, 1'b1, 8'hEE);
    cycle();
    exp_word = exp_q.pop_front();
    check("ovf_usedw", l_usedw, 4'd7);
    check("ovf_pulse", l_ovf, 1'b1);
    check("ovf_q", l_q, exp_word);
    check("ovf_not_full", l_full, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    cycle();
    check("ovf_pulse_end", l_ovf, 1'b0);
    check("ovf_usedw_hold", l_usedw, 4'd7);

    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b1, 8'h00);
      cycle();
      exp_word = exp_q.pop_front();
      check("ovf_drain_q", l_q, exp_word);
    end
    check("ovf_drain_empty", l_empty, 1'b1);

    // show-ahead: word visible with no rdreq
    drive(1'b1, 1'b0, 8'hA5);
    cycle();
    check("sa_empty", s_empty, 1'b0);
    check("sa_q", s_q, 8'hA5);
    check("sa_usedw", s_usedw, 4'd1);
    drive(1'b0, 1'b1, 8'h00);
    cycle();
    check("sa_pop_empty", s_empty, 1'b1);
    check("sa_leg_q", l_q, 8'hA5);

    // streaming at usedw=3 across pointer wrap
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'(8'hC0 + k));
      exp_q.push_back(8'(8'hC0 + k));
      cycle();
    end
    check("stream_pre_usedw", l_usedw, 4'd3);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 8'(8'h10 + k));
      exp_q.push_back(8'(8'h10 + k));
      cycle();
      exp_word = exp_q.pop_front();
      check("stream_q", l_q, exp_word);
      check("stream_usedw", l_usedw, 4'd3);
      check("stream_sa_head", s_q, exp_q[0]);
    end

    // sclr at usedw=5 beats a concurrent write
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 8'(8'h50 + k));
      cycle();
    end
    check("sclr_pre_usedw", l_usedw, 4'd5);
    sclr = 1'b1;
    drive(1'b1, 1'b0, 8'h77);
    cycle();
    sclr = 1'b0;
    exp_q.delete();
    check("sclr_usedw", l_usedw, 4'd0);
    check("sclr_empty", l_empty, 1'b1);
    check("sclr_ae", l_ae, 1'b1);
    check("sclr_q", l_q, 8'h00);
    check("sclr_sa_usedw", s_usedw, 4'd0);
    drive(1'b1, 1'b0, 8'h12);
    cycle();
    check("post_sclr_usedw", l_usedw, 4'd1);
    check("post_sclr_sa_q", s_q, 8'h12);
    drive(1'b0, 1'b1, 8'h00);
    cycle();
    check("post_sclr_q", l_q, 8'h12);
    check("post_sclr_empty", l_empty, 1'b1);

    // async reset asserted between edges
    drive(1'b1, 1'b0, 8'h21);
    cycle();
    drive(1'b1, 1'b0, 8'h22);
    cycle();
    check("pre_arst_usedw", l_usedw, 4'd2);
    #3 aclr_n = 1'b0;
    #1;
    check("arst_usedw", l_usedw, 4'd0);
    check("arst_empty", l_empty, 1'b1);
    check("arst_ae", l_ae, 1'b1);
    check("arst_q", l_q, 8'h00);
    check("arst_sa_usedw", s_usedw, 4'd0);
    drive(1'b0, 1'b0, 8'h00);
    #1 aclr_n = 1'b1;
    cycle();
    check("post_arst_empty", l_empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised single-clock FIFO, the successor to the fixed 8-bit/256-word FIFO used on the board's byte data paths. Adds configurable width and depth, a selectable show-ahead read mode, programmable almost-full/almost-empty thresholds, a synchronous clear, and one-cycle overflow/underflow error pulses. Sits between any producer/consumer pair sharing `clock`, e.g. serial receiver to processing logic.

## Interface
- `WIDTH`, 8: data word width in bits.
- `DEPTH_LOG2`, 8: log2 of depth; DEPTH = 2^DEPTH_LOG2 words.
- `SHOW_AHEAD`, 0: 0 = legacy read mode (q registered after rdreq); 1 = show-ahead (q presents head word while not empty).
- `AF_LEVEL`, DEPTH-4: almost_full asserts when usedw >= AF_LEVEL.
- `AE_LEVEL`, 4: almost_empty asserts when usedw < AE_LEVEL.

- `clock` in 1: single clock; all state updates on its rising edge.
- `aclr_n` in 1: asynchronous, active-low reset.
- `sclr` in 1: synchronous clear, active high.
- `data` in WIDTH: write data.
- `wrreq` in 1: write request.
- `rdreq` in 1: read request / acknowledge.
- `q` out WIDTH: read data.
- `full` out 1: DEPTH words stored.
- `empty` out 1: zero words stored.
- `almost_full` out 1: usedw >= AF_LEVEL.
- `almost_empty` out 1: usedw < AE_LEVEL.
- `usedw` out DEPTH_LOG2+1: stored word count, 0..DEPTH; no wrap at full.
- `wr_ovf` out 1: one-cycle pulse, write requested while full.
- `rd_unf` out 1: one-cycle pulse, read requested while empty.

## Operation
- Storage: DEPTH x WIDTH array, write pointer and read pointer each DEPTH_LOG2 bits, wrap modulo DEPTH.
- Write accepted iff wrreq && !full: mem[wr_ptr] <= data, wr_ptr++.
- Read accepted iff rdreq && !empty: rd_ptr++.
- Acceptance is judged on the current-cycle flags only; a read in the same cycle never frees room for a write when full, and a write never makes data readable when empty.
- Count: usedw_next = usedw + wr_acc - rd_acc; both accepted leaves usedw unchanged.
- Full + wrreq + rdreq: read only, usedw decrements, wr_ovf pulses, data dropped.
- Empty + wrreq + rdreq: write only, usedw increments, rd_unf pulses.
- Rejected requests change no pointer, count, memory, or q.
- Legacy mode: on accepted read, q <= mem[rd_ptr] at that edge; q holds otherwise.
- Show-ahead mode: q = mem[rd_ptr] continuously; valid only while !empty; rdreq pops the displayed word. While empty, q is don't-care; bench must not check it.
- sclr: pointers, usedw, and flags return to reset values at the edge; sclr has priority over wrreq/rdreq; legacy q is cleared to 0; memory contents are not cleared.
- Thresholds: parameters must satisfy 1 <= AE_LEVEL <= AF_LEVEL <= DEPTH; no runtime check.

## Timing
- Reset (aclr_n low, immediate): usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, wr_ovf=0, rd_unf=0, legacy q=0, pointers=0.
- Release of aclr_n is synchronised by the integrator; first operation is permitted on the first edge after release.
- Reset asserted mid-operation aborts everything; in-flight words are lost.
- All flags and usedw are registered and computed from usedw_next; they change at the same edge that accepts the operation.
- Write latency: a word written at edge N makes empty deassert after edge N. Legacy mode can read it with rdreq at edge N+1, and q shows it after edge N+1. Show-ahead mode shows it on q after edge N.
- Legacy read latency: 1 clock from rdreq edge to q.
- wr_ovf and rd_unf are registered, high for exactly the cycle after the offending edge.
- Sustained simultaneous write/read at 1 word/clock is supported at any fill level 1..DEPTH-1.

## Test plan
- Reset/fill, WIDTH=8, DEPTH_LOG2=3: write 0x01..0x08 on consecutive clocks. Required: usedw steps 1..8; almost_full rises when usedw reaches AF_LEVEL=4; full=1 after 8th edge; usedw=8, not 0.
- Drain (legacy): from full, rdreq for 8 clocks. Required: q = 0x01..0x08, each one clock after its rdreq edge; empty=1 and usedw=0 after 8th edge; almost_empty set when usedw < 4.
- Overflow/underflow: full + wrreq=1 + rdreq=1. Required: usedw 8->7, wr_ovf pulses one cycle, the dropped word never appears. Empty + both requests: usedw 0->1, rd_unf pulses.
- Show-ahead, SHOW_AHEAD=1: write 0xA5 into empty. Required: after the edge, empty=0 and q=0xA5 with no rdreq. Then rdreq: empty=1.
- Wrap/streaming: 20 clocks of simultaneous write (incrementing data) and read at usedw=3. Required: usedw stays 3, read data sequence is exact across pointer wrap.
- sclr and async reset: assert sclr with wrreq=1 at usedw=5. Required: usedw=0, empty=1, nothing written. Pull aclr_n low mid-clock: outputs go to reset values before the next edge.
